uart_rx_framer: RTL and testbench

//  System-clock UART receive front end. Samples the serial line (rx_data) at 16x baud via a tick enable,

---
 rtl/uart_pkg.sv | 24 ++
 rtl/byte_fifo.sv | 65 ++++++
 rtl/uart_rx_framer.sv | 157 +++++++++++++++
 tb/tb_uart_rx_framer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART receive-path constants, FSM encoding, voter helper
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int unsigned c_data_bits  = 8;
  localparam int unsigned c_oversample = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// byte_fifo : synchronous FIFO, simultaneous push/pop allowed when full
// Rev 1.0
// ============================================================================
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_cnt_w = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q;
  logic [c_ptr_w-1:0] rd_ptr_q;
  logic [c_cnt_w-1:0] count_q;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full  = (count_q == c_cnt_w'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_pop   = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs
  assign w_push  = push_i & (~w_full | w_pop);
  assign drop_o  = push_i & w_full & ~w_pop;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + c_cnt_w'(1);
      end else if (w_pop && !w_push) begin
        count_q <= count_q - c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_framer.sv
`default_nettype none
// ============================================================================
// uart_rx_framer : oversampled UART receiver with majority vote and byte FIFO
// Rev 1.0
// ============================================================================
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = c_data_bits,
  parameter int unsigned OVERSAMPLE = c_oversample,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx_data,
  output logic [DATA_BITS-1:0] byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned c_os_w  = $clog2(OVERSAMPLE);
  localparam int unsigned c_bit_w = $clog2(DATA_BITS);

  localparam logic [c_os_w-1:0]  c_os_last  = c_os_w'(OVERSAMPLE - 1);
  localparam logic [c_os_w-1:0]  c_samp_lo  = c_os_w'(OVERSAMPLE / 2 - 1);
  localparam logic [c_os_w-1:0]  c_samp_mid = c_os_w'(OVERSAMPLE / 2);
  localparam logic [c_os_w-1:0]  c_samp_hi  = c_os_w'(OVERSAMPLE / 2 + 1);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [c_os_w-1:0]    os_cnt_q, os_cnt_d;
  logic [c_bit_w-1:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q;

  logic w_rx_s;
  logic w_tick_run;
  logic w_decide;
  logic w_bit;
  logic w_push;
  logic w_empty;
  logic w_drop;

  assign w_rx_s     = sync2_q;
  assign w_tick_run = os_tick &&
                      (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP);
  assign w_decide   = w_tick_run && (os_cnt_q == c_samp_hi);
  // Third vote is the live line on the decision tick itself
  assign w_bit      = maj3(samp_q[0], samp_q[1], w_rx_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx_data;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= w_drop;
    end
  end

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    w_push      = 1'b0;

    if (w_tick_run) begin
      os_cnt_d = (os_cnt_q == c_os_last) ? '0 : os_cnt_q + c_os_w'(1);
      if (os_cnt_q == c_samp_lo)  samp_d[0] = w_rx_s;
      if (os_cnt_q == c_samp_mid) samp_d[1] = w_rx_s;
    end

    unique case (state_q)
      ST_IDLE: begin
        os_cnt_d = '0;
        if (!w_rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (w_decide) begin
          if (w_bit) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (w_decide) begin
          shreg_d = {w_bit, shreg_q[DATA_BITS-1:1]};
          if (bit_cnt_q == c_bit_last) state_d = ST_STOP;
          else                         bit_cnt_d = bit_cnt_q + c_bit_w'(1);
        end
      end
      ST_STOP: begin
        if (w_decide) begin
          if (w_bit) begin
            w_push  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .data_i  (shreg_q),
    .pop_i   (byte_valid & byte_ready),
    .data_o  (byte_out),
    .empty_o (w_empty),
    .drop_o  (w_drop)
  );

  assign byte_valid = ~w_empty;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_framer.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_framer : directed self-checking bench, os_tick every 4 clk
// Rev 1.0
// ============================================================================
module tb_uart_rx_framer;

  localparam int c_bt = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       os_tick;
  logic       rx_data;
  logic       byte_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int ferr_cyc = 0;
  int ovr_cyc  = 0;
  int vld_cyc  = 0;
  int tph      = 0;
  logic [7:0] popped[$];

  uart_rx_framer dut (
    .clk        (clk),
    .reset      (reset),
    .os_tick    (os_tick),
    .rx_data    (rx_data),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    os_tick = 1'b0;
    forever begin
      @(negedge clk);
      tph     = (tph + 1) % 4;
      os_tick = (tph == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (frame_err) ferr_cyc++;
      if (overrun) ovr_cyc++;
      if (byte_valid) vld_cyc++;
      if (byte_valid && byte_ready) popped.push_back(byte_out);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  task automatic clear_mon();
    ferr_cyc = 0;
    ovr_cyc  = 0;
    vld_cyc  = 0;
    popped.delete();
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_data = 1'b0;
    wait_clk(c_bt);
    for (int i = 0; i < 8; i++) begin
      rx_data = d[i];
      wait_clk(c_bt);
    end
    rx_data = stop_bit;
    wait_clk(c_bt);
  endtask

  task automatic check_popped(input string name, input logic [7:0] exp[$]);
    checks++;
    if (popped.size() !== exp.size()) begin
      failures++;
      $display("FAIL %s count got=%0d exp=%0d", name, popped.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        if (popped[i] !== exp[i]) begin
          failures++;
          $display("FAIL %s byte%0d got=%02h exp=%02h", name, i, popped[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_data = 1'b1; byte_ready = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    #3;
    checks++;
    if ({byte_valid, busy, frame_err, overrun} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {byte_valid, busy, frame_err, overrun});
    end
    checks++;
    if (byte_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_byte_out got=%02h exp=00", byte_out);
    end
  endtask

  task automatic test_single_byte();
    byte_ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1);
    wait_clk(2 * c_bt);
    check_popped("single_a5", '{8'hA5});
    checks++;
    if (vld_cyc !== 1) begin
      failures++;
      $display("FAIL single_valid_cycles got=%0d exp=1", vld_cyc);
    end
    checks++;
    if (ferr_cyc + ovr_cyc !== 0) begin
      failures++;
      $display("FAIL single_flags got=%0d exp=0", ferr_cyc + ovr_cyc);
    end
  endtask

  task automatic test_overrun();
    byte_ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    wait_clk(c_bt);
    checks++;
    if (ovr_cyc !== 1 || ferr_cyc !== 0) begin
      failures++;
      $display("FAIL overrun_pulse got ovr=%0d ferr=%0d exp ovr=1 ferr=0", ovr_cyc, ferr_cyc);
    end
    checks++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h01) begin
      failures++;
      $display("FAIL overrun_head got v=%b d=%02h exp v=1 d=01", byte_valid, byte_out);
    end
    byte_ready = 1'b1;
    wait_clk(8);
    byte_ready = 1'b0;
    #3;
    check_popped("overrun_drain", '{8'h01, 8'h02, 8'h03, 8'h04});
    checks++;
    if (byte_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_empty got=%b exp=0", byte_valid);
    end
  endtask

  task automatic test_frame_error();
    byte_ready = 1'b1;
    clear_mon();
    send_frame(8'h3C, 1'b0);
    wait_clk(40 * c_bt);
    checks++;
    if (ferr_cyc !== 1 || ovr_cyc !== 0) begin
      failures++;
      $display("FAIL ferr_pulse got ferr=%0d ovr=%0d exp ferr=1 ovr=0", ferr_cyc, ovr_cyc);
    end
    check_popped("ferr_nopush", '{});
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL ferr_break_busy got=%b exp=1", busy);
    end
    rx_data = 1'b1;
    wait_clk(2 * c_bt);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ferr_release_busy got=%b exp=0", busy);
    end
    send_frame(8'h55, 1'b1);
    wait_clk(2 * c_bt);
    check_popped("ferr_then_55", '{8'h55});
    checks++;
    if (ferr_cyc !== 1) begin
      failures++;
      $display("FAIL ferr_single_total got=%0d exp=1", ferr_cyc);
    end
  endtask

  task automatic test_glitch();
    byte_ready = 1'b1;
    clear_mon();
    rx_data = 1'b0;
    wait_clk(16);
    rx_data = 1'b1;
    wait_clk(2 * c_bt);
    checks++;
    if (busy !== 1'b0 || ferr_cyc !== 0 || ovr_cyc !== 0 || popped.size() !== 0) begin
      failures++;
      $display("FAIL start_glitch got busy=%b ferr=%0d ovr=%0d n=%0d exp all 0",
               busy, ferr_cyc, ovr_cyc, popped.size());
    end
    // 0xFF with one low tick on the middle sample of bit 3
    rx_data = 1'b0;
    wait_clk(c_bt);
    for (int i = 0; i < 8; i++) begin
      rx_data = 1'b1;
      if (i == 3) begin
        wait_clk(34);
        rx_data = 1'b0;
        wait_clk(4);
        rx_data = 1'b1;
        wait_clk(c_bt - 38);
      end else begin
        wait_clk(c_bt);
      end
    end
    rx_data = 1'b1;
    wait_clk(3 * c_bt);
    check_popped("data_glitch_ff", '{8'hFF});
  endtask

  task automatic test_reset_mid_frame();
    byte_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clk(c_bt);
    rx_data = 1'b0;
    wait_clk(c_bt);
    for (int i = 0; i < 3; i++) begin
      rx_data = (i == 0 || i == 3);
      wait_clk(c_bt);
    end
    rx_data = 1'b1;
    wait_clk(c_bt / 2);
    checks++;
    if (busy !== 1'b1 || byte_valid !== 1'b1) begin
      failures++;
      $display("FAIL premid_state got busy=%b v=%b exp 1 1", busy, byte_valid);
    end
    reset = 1'b1;
    wait_clk(1);
    #3;
    checks++;
    if ({byte_valid, busy, frame_err, overrun} !== 4'b0000 || byte_out !== 8'h00) begin
      failures++;
      $display("FAIL midreset got flags=%b d=%02h exp flags=0000 d=00",
               {byte_valid, busy, frame_err, overrun}, byte_out);
    end
    reset = 1'b0;
    wait_clk(2 * c_bt);
    byte_ready = 1'b1;
    clear_mon();
    send_frame(8'h7E, 1'b1);
    wait_clk(2 * c_bt);
    check_popped("after_reset_7e", '{8'h7E});
  endtask

  task automatic test_full_push_pop();
    int guard;
    byte_ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 4; i++) send_frame(8'hA0 + 8'(i), 1'b1);
    wait_clk(c_bt);
    // Align the frame start with a tick so the stop decision lands 616 clk later
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (os_tick !== 1'b1 && guard < 8);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (616) @(posedge clk);
        @(negedge clk);
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
      end
    join
    wait_clk(c_bt);
    checks++;
    if (ovr_cyc !== 0) begin
      failures++;
      $display("FAIL full_pushpop_overrun got=%0d exp=0", ovr_cyc);
    end
    check_popped("full_pushpop_first", '{8'hA1});
    byte_ready = 1'b1;
    wait_clk(10);
    byte_ready = 1'b0;
    check_popped("full_pushpop_order", '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5});
  endtask

  initial begin
    reset = 1'b1;
    rx_data = 1'b1;
    byte_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_full_push_pop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
